// File: rtl/l2_cache_control.sv
// ----------------------------------------------------------------------------
// l2_cache_control
//
// Control FSM for a two-way set-associative L2 cache. The datapath reports
// per-way hits, the set's LRU bit and its dirty bits. This block sequences
// hit service, victim writeback and line fill, and counts misses.
//
// Ports
//   clk, rst        : sole clock; synchronous active-high reset
//   mem_read/write  : L1 request, held until mem_resp
//   mem_resp        : one-cycle completion pulse back to L1
//   hit1, hit2      : way-1 / way-2 tag match and valid
//   lru             : victim way select (0 = way 1, 1 = way 2)
//   dirty[1:0]      : dirty bits of the indexed set ([0] way 1, [1] way 2)
//   pmem_read/write : fill / writeback request to physical memory
//   pmem_resp       : physical memory completion pulse
//   load_data/tag/dirty[1:0] : per-way array write enables
//   dirty_in        : value written with load_dirty
//   load_lru/lru_in : LRU write enable and value
//   wdata_sel       : data source, 0 hit-path write data, 1 pmem_rdata
//   pmem_addr_sel   : 0 request address, 1 victim tag + index
//   miss_count      : saturating count of misses since reset
// ----------------------------------------------------------------------------
module l2_cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   input  logic                 hit1,
   input  logic                 hit2,
   input  logic                 lru,
   input  logic [1:0]           dirty,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   output logic [1:0]           load_data,
   output logic [1:0]           load_tag,
   output logic [1:0]           load_dirty,
   output logic                 dirty_in,
   output logic                 load_lru,
   output logic                 lru_in,
   output logic                 wdata_sel,
   output logic                 pmem_addr_sel,
   output logic [CNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

   logic       hit_s;
   logic       is_write_s;
   logic [1:0] hit_mask_s;
   logic [1:0] victim_mask_s;

   // A request with both read and write high is a write. When both ways
   // report a hit, way 1 wins.
   assign hit_s         = hit1 | hit2;
   assign is_write_s    = mem_write;
   assign hit_mask_s    = hit1 ? 2'b01 : 2'b10;
   assign victim_mask_s = lru ? 2'b10 : 2'b01;
   assign miss_count    = miss_count_q;

   // State and miss counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         miss_count_q <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Next-state logic and saturating miss counter update.
   always_comb begin
      state_d      = state_q;
      miss_count_d = miss_count_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               state_d = COMPARE;
            end else begin
               state_d = IDLE;
            end
         end
         COMPARE: begin
            if (hit_s) begin
               state_d = IDLE;
            end else begin
               // Only counted on the miss path; leaving COMPARE guarantees
               // one increment per miss.
               if (!(&miss_count_q)) begin
                  miss_count_d = miss_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  miss_count_d = miss_count_q;
               end
               if (dirty[lru]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            if (pmem_resp) begin
               state_d = ALLOCATE;
            end else begin
               state_d = WRITEBACK;
            end
         end
         ALLOCATE: begin
            // Return to COMPARE so the freshly filled line is served as a hit.
            if (pmem_resp) begin
               state_d = COMPARE;
            end else begin
               state_d = ALLOCATE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from state and datapath status; unnamed outputs stay 0.
   always_comb begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      load_data     = 2'b00;
      load_tag      = 2'b00;
      load_dirty    = 2'b00;
      dirty_in      = 1'b0;
      load_lru      = 1'b0;
      lru_in        = 1'b0;
      wdata_sel     = 1'b0;
      pmem_addr_sel = 1'b0;
      case (state_q)
         IDLE: begin
            mem_resp = 1'b0;
         end
         COMPARE: begin
            if (hit_s) begin
               mem_resp = 1'b1;
               load_lru = 1'b1;
               // The way just used becomes most recent; the other is victim.
               lru_in   = hit1;
               if (is_write_s) begin
                  load_data  = hit_mask_s;
                  load_dirty = hit_mask_s;
                  dirty_in   = 1'b1;
                  wdata_sel  = 1'b0;
               end else begin
                  load_data  = 2'b00;
               end
            end else begin
               mem_resp = 1'b0;
            end
         end
         WRITEBACK: begin
            if (!pmem_resp) begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
            end else begin
               pmem_write    = 1'b0;
            end
         end
         ALLOCATE: begin
            if (!pmem_resp) begin
               pmem_read = 1'b1;
            end else begin
               load_data  = victim_mask_s;
               load_tag   = victim_mask_s;
               load_dirty = victim_mask_s;
               dirty_in   = 1'b0;
               wdata_sel  = 1'b1;
            end
         end
         default: begin
            mem_resp = 1'b0;
         end
      endcase
   end

endmodule
